// File: rtl/mdu_sequencer.sv
// mdu_sequencer: control sequencer for the iterative multiply/divide unit.
// Ports: clk/reset; StartE, IsDivE, DivZeroE, Kill in; MduStall, LoadE, StepE, IterCnt, DoneE, Busy out.
module mdu_sequencer #(
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       StartE,
   input  logic       IsDivE,
   input  logic       DivZeroE,
   input  logic       Kill,
   output logic       MduStall,
   output logic       LoadE,
   output logic       StepE,
   output logic [5:0] IterCnt,
   output logic       DoneE,
   output logic       Busy
);

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DIV,
      DONE
   } stateT;

   localparam logic [5:0] MulLast = 6'(MUL_CYCLES - 1);
   localparam logic [5:0] DivLast = 6'(DIV_CYCLES - 1);

   stateT      state;
   logic [5:0] iterCnt;
   logic       abort;
   logic       launch;
   logic       iterating;
   logic       lastIter;

   // reset and Kill both squash every request in the cycle they appear
   assign abort     = reset | Kill;
   assign launch    = (state == IDLE) & StartE & !abort;
   assign iterating = (state == MUL) | (state == DIV);
   assign lastIter  = ((state == MUL) & (iterCnt == MulLast)) |
                      ((state == DIV) & (iterCnt == DivLast));

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         iterCnt <= '0;
      end else if (Kill) begin
         state   <= IDLE;
         iterCnt <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (StartE) begin
                  iterCnt <= '0;
                  if (!IsDivE)
                     state <= MUL;
                  else if (DivZeroE)
                     state <= DONE;
                  else
                     state <= DIV;
               end
            end
            MUL, DIV: begin
               // hold the final index so the count never wraps
               if (lastIter)
                  state <= DONE;
               else
                  iterCnt <= iterCnt + 6'd1;
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign LoadE    = launch;
   assign MduStall = launch | (iterating & !abort);
   assign StepE    = iterating & !abort;
   assign DoneE    = (state == DONE) & !abort;
   assign Busy     = (state != IDLE) & !reset;
   assign IterCnt  = reset ? 6'd0 : iterCnt;

endmodule
